// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared defaults and depth validation for the shift_reg_siso delay line
package shift_reg_pkg;

    localparam int   DEPTH_DEFAULT       = 4;
    localparam int   DEPTH_MAX           = 64;
    localparam logic RESET_VALUE_DEFAULT = 1'b0;

    function automatic bit depth_ok(input int d);
        return (d >= 1) && (d <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/dff_arst_n.sv
// dff_arst_n: single-bit D flop with asynchronous active-low reset to RST_VAL
module dff_arst_n #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_q;

    // Capture d on every rising edge; reset forces the stored bit to RST_VAL immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= RST_VAL;
        else          r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/shift_reg_siso.sv
// shift_reg_siso: serial-in serial-out delay line of DEPTH flops; define SHIFT_REG_SISO_TAPS_EN to expose all stages on taps
module shift_reg_siso
    import shift_reg_pkg::*;
#(
    parameter int   DEPTH       = DEPTH_DEFAULT,
    parameter logic RESET_VALUE = RESET_VALUE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sdi,
`ifdef SHIFT_REG_SISO_TAPS_EN
    output logic [DEPTH-1:0] taps,
`endif
    output logic             sdo
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("shift_reg_siso: DEPTH=%0d outside 1..%0d", DEPTH, DEPTH_MAX);
    end

    // w_chain[0] is the serial input, w_chain[i+1] is stage[i]
    logic [DEPTH:0] w_chain;

    assign w_chain[0] = sdi;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_arst_n #(.RST_VAL(RESET_VALUE)) u_dff (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (w_chain[i]),
            .q       (w_chain[i+1])
        );
    end

    assign sdo = w_chain[DEPTH];

`ifdef SHIFT_REG_SISO_TAPS_EN
    assign taps = w_chain[DEPTH:1];
`endif

endmodule

// File: tb/tb_shift_reg_siso.sv
// tb_shift_reg_siso: directed plus random checks of three delay-line depths against a sample-history model
module tb_shift_reg_siso;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sdi = 1'b0;
    logic sdo1, sdo4, sdo64;
`ifdef SHIFT_REG_SISO_TAPS_EN
    logic [3:0] taps4;
    logic [0:0] taps1;
    logic [63:0] taps64;
`endif

    int total = 0;
    int bad = 0;
    bit hist[$];

    always #5 clk = ~clk;

    shift_reg_siso #(.DEPTH(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .sdi(sdi),
`ifdef SHIFT_REG_SISO_TAPS_EN
        .taps(taps1),
`endif
        .sdo(sdo1)
    );

    shift_reg_siso #(.DEPTH(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .sdi(sdi),
`ifdef SHIFT_REG_SISO_TAPS_EN
        .taps(taps4),
`endif
        .sdo(sdo4)
    );

    shift_reg_siso #(.DEPTH(64)) u_d64 (
        .clk(clk), .reset_n(reset_n), .sdi(sdi),
`ifdef SHIFT_REG_SISO_TAPS_EN
        .taps(taps64),
`endif
        .sdo(sdo64)
    );

    // A bit sampled d edges ago is what a depth-d line shows; before that, the reset value
    function automatic logic exp_at(input int d);
        int n = hist.size();
        return (n >= d) ? logic'(hist[n-d]) : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":d1"}, sdo1, exp_at(1));
        chk({tag, ":d4"}, sdo4, exp_at(4));
        chk({tag, ":d64"}, sdo64, exp_at(64));
`ifdef SHIFT_REG_SISO_TAPS_EN
        for (int i = 0; i < 4; i++) chk($sformatf("%s:tap%0d", tag, i), taps4[i], exp_at(i + 1));
        chk({tag, ":tap63"}, taps64[63], exp_at(64));
`endif
    endtask

    task automatic step(input logic b, input string tag);
        sdi = b;
        @(posedge clk);
        if (reset_n) hist.push_back(b);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1011_0010;
        #1;
        check_all("reset_init");
        for (int i = 0; i < 3; i++) step(logic'($urandom_range(0, 1)), "reset_hold");
        reset_n = 1'b1;
        step(1'b1, "pulse1");
        for (int i = 0; i < 6; i++) step(1'b0, "pulse1_tail");
        for (int i = 0; i < 5; i++) step(1'b0, "idle");
        step(1'b1, "pulse2");
        step(1'b1, "pulse2");
        for (int i = 0; i < 6; i++) step(1'b0, "pulse2_tail");
        for (int i = 7; i >= 0; i--) step(pat[i], "pattern");
        for (int i = 0; i < 4; i++) step(1'b0, "pattern_tail");
        for (int i = 0; i < 5; i++) step(1'b1, "preload");
        chk("preload_sdo4_high", sdo4, 1'b1);
        #2 reset_n = 1'b0;
        hist.delete();
        #1;
        check_all("async_reset");
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, "post_reset");
        step(1'b1, "pulse64");
        for (int i = 0; i < 70; i++) step(1'b0, "pulse64_tail");
        for (int i = 0; i < 200; i++) step(logic'($urandom_range(0, 1)), "random");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
